varint_stream_ctrl: RTL
=======================

# varint_stream_ctrl

Sequencer that takes 64-bit field values over a valid/ready handshake and streams their protobuf base-128 varint encoding out one byte per cycle. It instantiates the combinational `varint_ser` encoder on its input path, registers the 10-byte encoded word with its byte length, and walks the bytes onto a byte-wide output stream. It sits between the field-value source and the message byte packer. It also keeps a running byte count so the packer can fill in length-delimited headers.

## Interface
- No parameters. All widths are fixed by the wire format: 64-bit value, 8-bit bytes, at most 10 bytes per varint, 32-bit byte counter.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a value is offered.
- `in_ready` out 1: the block accepts the value this cycle.
- `in_value` in 64: raw field value.
- `in_zigzag` in 1: when 1, zigzag-encode `in_value` before encoding (sint32/sint64 fields).
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream takes the byte.
- `out_byte` out 8: the current encoded byte, including its continuation bit.
- `out_last` out 1: `out_byte` is the final byte of the current varint.
- `byte_count` out 32: number of bytes handed off since reset or the last clear.
- `cnt_clr` in 1: synchronous clear of `byte_count`.

## Operation
- Zigzag: `v = in_zigzag ? ((in_value << 1) ^ {64{in_value[63]}}) : in_value`.
- `v` feeds `varint_ser`, which produces an 80-bit word. Byte i is bits [8i+7:8i], and bit 8i+7 is the continuation bit.
- Length `len` = 1 + the number of set continuation bits among bytes 0..8. Range is 1..10 (4 bits).
- State `IDLE`:
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid`: register the word and `len`, set `idx=0`, go to `EMIT`.
- State `EMIT`:
  - `out_valid=1`, `out_byte = word[idx]`, `out_last = (idx == len-1)`.
  - On `out_ready` with `!out_last`: `idx++`.
  - On `out_ready` with `out_last`: if `in_valid`, capture the new value and set `idx=0` (stay in `EMIT`); otherwise go to `IDLE`.
- `in_ready = (state==IDLE) | (state==EMIT & out_last & out_ready)`. This is combinational from `out_ready`, and it allows back-to-back varints with no bubble.
- Outputs are stable while `out_valid & !out_ready`. The captured word is never modified mid-emission, and `in_value` changes have no effect after capture.
- `byte_count`:
  - Increments on each `out_valid & out_ready`.
  - Saturates at 0xFFFF_FFFF.
  - `cnt_clr` with no handshake in the same cycle gives 0.
  - `cnt_clr` together with a handshake gives 1.
- Encoding results:
  - A zero value encodes to the single byte 0x00.
  - 2^64-1 encodes to 10 bytes: 0xFF ×9, then 0x01.

## Timing
- Reset values: state `IDLE`, `idx=0`, word=0, `len=1`, `out_valid=0`, `out_byte=0x00`, `out_last=0`, `byte_count=0`, `in_ready=1` (in reset: 0 while `rst_n` low).
- Latency: a value accepted at edge N has its first byte valid after N, i.e. in cycle N+1.
- Throughput: 1 byte/cycle with `out_ready` held high. A stream of varints of length L1, L2, … occupies exactly ΣLi cycles.
- Reset mid-emission: the remaining bytes are dropped, `out_valid` drops asynchronously, and nothing is replayed.
- `idx` never exceeds 9. An `out_ready` while `out_valid=0` is ignored.

## Structure
- Package `pb_pkg`:
  - `BYTE` = 8.
  - `VARINT_MAX_BYTES` = 10.
  - `typedef enum logic {IDLE, EMIT} vs_state_t`.
  - `typedef logic [79:0] varint_word_t`.
  - A zigzag64 function.
- One sub-module, `varint_ser`, instantiated unchanged on the input path.
- The length popcount and the byte mux stay inline.

## Test plan
- `in_value=0`, `zigzag=0` → one byte 0x00 with `out_last=1`; `byte_count=1`.
- `in_value=300` → 0xAC then 0x02 (`last` on the second byte); `in_ready` low on cycle 1 of emission.
- `in_value=64'hFFFF_FFFF_FFFF_FFFF` → 0xFF ×9 then 0x01; `last` only on the 10th byte.
- `in_value=-1`, `zigzag=1` → single byte 0x01. `in_value=1`, `zigzag=1` → single byte 0x02.
- 300 then 1 offered back-to-back with `out_ready=1` → 0xAC, 0x02, 0x01 on 3 consecutive cycles.
- Random `out_ready` stalls → `out_byte`/`out_last` held constant while stalled, and the byte sequence is unchanged.
- Reset asserted mid-stream of 2^64-1 after 4 bytes → all outputs return to reset values. Then `in_value=5` → the single byte 0x05 and `byte_count=1`.
- `cnt_clr` together with a handshake → `byte_count=1`.

Source files
------------

// File: rtl/pb_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the protobuf wire-format blocks.
// Provides byte/varint sizing constants, the varint streamer state type,
// the 80-bit encoded word type and a zigzag64 helper for sint fields.
package pb_pkg;

  localparam int unsigned BYTE             = 8;
  localparam int unsigned VARINT_MAX_BYTES = 10;

  typedef enum logic {IDLE, EMIT} vs_state_t;

  typedef logic [79:0] varint_word_t;

  // Maps signed values to unsigned so small magnitudes stay short.
  function automatic logic [63:0] zigzag64(input logic [63:0] v);
    return (v << 1) ^ {64{v[63]}};
  endfunction

endpackage

// File: rtl/varint_ser.sv
`timescale 1ns/1ps
// Combinational base-128 varint encoder.
// Ports:
//   value - 64-bit unsigned input
//   word  - 10 encoded bytes, byte i at [8i+7:8i], bit 8i+7 = continuation
// Bytes beyond the encoded length are zero, so their continuation bits are
// clear and the length can be recovered by counting continuation bits.
module varint_ser
  import pb_pkg::*;
(
  input  logic [63:0]  value,
  output varint_word_t word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < VARINT_MAX_BYTES - 1; i++) begin
      word[i*BYTE +: 7]  = value[i*7 +: 7];
      // Continue if any higher payload bit is still set.
      word[i*BYTE + 7]   = |(value >> (7 * (i + 1)));
    end
    // Tenth byte carries only bit 63 and never continues.
    word[72] = value[63];
  end

endmodule

// File: rtl/varint_stream_ctrl.sv
`timescale 1ns/1ps
// Varint byte streamer.
// Accepts 64-bit field values (optionally zigzagged) on a valid/ready input,
// encodes them with varint_ser, and emits the encoded bytes one per cycle on
// a valid/ready byte stream with an end-of-varint marker. Keeps a saturating
// count of bytes handed off for length-delimited headers.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   in_valid/in_ready/in_value      - value input handshake
//   in_zigzag                       - zigzag-encode in_value before encoding
//   out_valid/out_ready/out_byte    - byte output handshake
//   out_last                        - out_byte is the final byte of its varint
//   byte_count/cnt_clr              - handed-off byte counter and its clear
module varint_stream_ctrl
  import pb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic        in_zigzag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [31:0] byte_count,
  input  logic        cnt_clr
);

  logic [63:0]  ser_value;
  varint_word_t ser_word;
  logic [3:0]   ser_len;

  vs_state_t    state_q;
  varint_word_t word_q;
  logic [3:0]   len_q;
  logic [3:0]   idx_q;
  logic [3:0]   idx_nxt;
  logic         fire;

  assign ser_value = in_zigzag ? zigzag64(in_value) : in_value;

  varint_ser u_ser (
    .value(ser_value),
    .word (ser_word)
  );

  always_comb begin
    ser_len = 4'd1;
    for (int i = 0; i < VARINT_MAX_BYTES - 1; i++) begin
      ser_len = ser_len + {3'b000, ser_word[i*BYTE + 7]};
    end
  end

  assign fire    = out_valid & out_ready;
  assign idx_nxt = idx_q + 4'd1;

  // Combinational path from out_ready lets the next value load on the same
  // edge the last byte leaves, so consecutive varints have no bubble.
  assign in_ready = rst_n & ((state_q == IDLE) |
                             ((state_q == EMIT) & out_last & out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      len_q     <= 4'd1;
      idx_q     <= 4'd0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= EMIT;
            word_q    <= ser_word;
            len_q     <= ser_len;
            idx_q     <= 4'd0;
            out_valid <= 1'b1;
            out_byte  <= ser_word[7:0];
            out_last  <= (ser_len == 4'd1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!out_last) begin
              idx_q    <= idx_nxt;
              out_byte <= word_q[{idx_nxt, 3'b000} +: BYTE];
              out_last <= (idx_nxt == len_q - 4'd1);
            end else if (in_valid) begin
              word_q    <= ser_word;
              len_q     <= ser_len;
              idx_q     <= 4'd0;
              out_valid <= 1'b1;
              out_byte  <= ser_word[7:0];
              out_last  <= (ser_len == 4'd1);
            end else begin
              state_q   <= IDLE;
              idx_q     <= 4'd0;
              out_valid <= 1'b0;
              out_byte  <= 8'h00;
              out_last  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= 32'd0;
    end else if (cnt_clr) begin
      byte_count <= fire ? 32'd1 : 32'd0;
    end else if (fire && (byte_count != 32'hFFFF_FFFF)) begin
      byte_count <= byte_count + 32'd1;
    end
  end

endmodule
